// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
//  Module      : multicycle_ctrl_if
//  Description : Handshake and strobe bundle between the multicycle
//                controller and its fetch unit, ALU flags, data memory
//                and datapath.
//                master : the environment (fetch unit, flags, memory).
//                         Drives instr_valid, opcode, zero_flag, neg_flag
//                         and mem_ready.
//                slave  : the controller. Drives instr_ack, gen, alu_op,
//                         alu_src_imm, reg_write, mem_read, mem_write,
//                         pc_write, pc_src, busy and err.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if #(
    parameter int OPW = 4
);
    logic           instr_valid;
    logic [OPW-1:0] opcode;
    logic           zero_flag;
    logic           neg_flag;
    logic           mem_ready;

    logic           instr_ack;
    logic           gen;
    logic [2:0]     alu_op;
    logic           alu_src_imm;
    logic           reg_write;
    logic           mem_read;
    logic           mem_write;
    logic           pc_write;
    logic [1:0]     pc_src;
    logic           busy;
    logic           err;

    modport master (
        output instr_valid, opcode, zero_flag, neg_flag, mem_ready,
        input  instr_ack, gen, alu_op, alu_src_imm, reg_write, mem_read,
               mem_write, pc_write, pc_src, busy, err
    );

    modport slave (
        input  instr_valid, opcode, zero_flag, neg_flag, mem_ready,
        output instr_ack, gen, alu_op, alu_src_imm, reg_write, mem_read,
               mem_write, pc_write, pc_src, busy, err
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Control FSM for a multicycle processor.
//                States are FETCH, DECODE, EXEC, MEM, WB and HALT.
//                Outputs are datapath strobes, the immediate-generator
//                select, the ALU operation and the PC source. An illegal
//                opcode or a data-memory timeout sets a sticky error and
//                parks the FSM in HALT until reset.
//  Ports       : clk         - clock, every state change on the rising edge
//                rst         - synchronous active-high reset
//                bus.slave   - instr_valid/opcode/zero_flag/neg_flag/
//                              mem_ready in; instr_ack, gen, alu_op,
//                              alu_src_imm, reg_write, mem_read, mem_write,
//                              pc_write, pc_src, busy, err out
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
    parameter int OPW     = 4,
    parameter int MEM_TMO = 15
) (
    input  wire logic        clk,
    input  wire logic        rst,
    multicycle_ctrl_if.slave bus
);

    localparam logic [2:0] c_S_FETCH  = 3'd0;
    localparam logic [2:0] c_S_DECODE = 3'd1;
    localparam logic [2:0] c_S_EXEC   = 3'd2;
    localparam logic [2:0] c_S_MEM    = 3'd3;
    localparam logic [2:0] c_S_WB     = 3'd4;
    localparam logic [2:0] c_S_HALT   = 3'd5;

    localparam logic [OPW-1:0] c_OP_NOP  = OPW'(4'b0000);
    localparam logic [OPW-1:0] c_OP_ST   = OPW'(4'b0011);
    localparam logic [OPW-1:0] c_OP_ADD  = OPW'(4'b0100);
    localparam logic [OPW-1:0] c_OP_INC  = OPW'(4'b0101);
    localparam logic [OPW-1:0] c_OP_NEG  = OPW'(4'b0110);
    localparam logic [OPW-1:0] c_OP_SUB  = OPW'(4'b0111);
    localparam logic [OPW-1:0] c_OP_J    = OPW'(4'b1000);
    localparam logic [OPW-1:0] c_OP_BRZ  = OPW'(4'b1001);
    localparam logic [OPW-1:0] c_OP_JM   = OPW'(4'b1010);
    localparam logic [OPW-1:0] c_OP_BRN  = OPW'(4'b1011);
    localparam logic [OPW-1:0] c_OP_LD   = OPW'(4'b1110);
    localparam logic [OPW-1:0] c_OP_SVPC = OPW'(4'b1111);

    localparam logic [2:0] c_ALU_PASS = 3'd0;
    localparam logic [2:0] c_ALU_ADD  = 3'd1;
    localparam logic [2:0] c_ALU_INC  = 3'd2;
    localparam logic [2:0] c_ALU_NEG  = 3'd3;
    localparam logic [2:0] c_ALU_SUB  = 3'd4;

    localparam logic [1:0] c_PC_SEQ = 2'd0;
    localparam logic [1:0] c_PC_REG = 2'd1;
    localparam logic [1:0] c_PC_MEM = 2'd2;

    localparam logic [7:0] c_MEM_TMO = 8'(MEM_TMO);

    function automatic logic f_legal(input logic [OPW-1:0] op);
        return op inside {c_OP_NOP, c_OP_SVPC, c_OP_LD, c_OP_ST, c_OP_ADD,
                          c_OP_INC, c_OP_NEG, c_OP_SUB, c_OP_J, c_OP_BRZ,
                          c_OP_JM, c_OP_BRN};
    endfunction

    function automatic logic f_is_alu(input logic [OPW-1:0] op);
        return op inside {c_OP_ADD, c_OP_SUB, c_OP_NEG, c_OP_INC, c_OP_SVPC};
    endfunction

    // Immediate operand: INC/SVPC use it as the ALU B input, LD/ST use it
    // as the address offset.
    function automatic logic f_use_imm(input logic [OPW-1:0] op);
        return op inside {c_OP_INC, c_OP_SVPC, c_OP_LD, c_OP_ST};
    endfunction

    function automatic logic [2:0] f_alu_op(input logic [OPW-1:0] op);
        logic [2:0] v;
        v = c_ALU_PASS;
        if (op == c_OP_ADD || op == c_OP_SVPC || op == c_OP_LD || op == c_OP_ST)
            v = c_ALU_ADD;
        else if (op == c_OP_INC)
            v = c_ALU_INC;
        else if (op == c_OP_NEG)
            v = c_ALU_NEG;
        else if (op == c_OP_SUB)
            v = c_ALU_SUB;
        return v;
    endfunction

    logic [2:0]     r_state;
    logic [OPW-1:0] r_op;
    logic           r_gen;
    logic           r_alu_src_imm;
    logic [2:0]     r_alu_op;
    logic           r_reg_write;
    logic           r_mem_read;
    logic           r_mem_write;
    logic           r_pc_write;
    logic [1:0]     r_pc_src;
    logic [7:0]     r_wait;
    logic           r_err;

    logic           w_op_nop;
    logic           w_op_alu;
    logic           w_op_ld;
    logic           w_op_st;
    logic           w_op_jm;
    logic           w_op_j;
    logic           w_op_br;
    logic           w_taken;
    logic           w_in_exec_br;
    logic           w_mem_done;
    logic [7:0]     w_wait_nxt;

    assign w_op_nop   = (r_op == c_OP_NOP);
    assign w_op_alu   = f_is_alu(r_op);
    assign w_op_ld    = (r_op == c_OP_LD);
    assign w_op_st    = (r_op == c_OP_ST);
    assign w_op_jm    = (r_op == c_OP_JM);
    assign w_op_j     = (r_op == c_OP_J);
    assign w_op_br    = (r_op == c_OP_BRZ) || (r_op == c_OP_BRN);
    assign w_taken    = ((r_op == c_OP_BRZ) && bus.zero_flag) ||
                        ((r_op == c_OP_BRN) && bus.neg_flag);
    assign w_in_exec_br = (r_state == c_S_EXEC) && w_op_br;
    // mem_ready only counts while an access is outstanding.
    assign w_mem_done = (r_state == c_S_MEM) && bus.mem_ready && !rst;
    assign w_wait_nxt = r_wait + 8'd1;

    // instr_ack and the ST/JM completion pc_write answer their input in the
    // same cycle so that neither acceptance nor memory completion costs a
    // cycle; everything else comes straight from registers.
    assign bus.instr_ack   = (r_state == c_S_FETCH) && bus.instr_valid && !rst;
    assign bus.pc_write    = r_pc_write || (w_mem_done && (w_op_st || w_op_jm));
    // Branch outcome uses the flags as they stand in the EXEC cycle.
    assign bus.pc_src      = w_in_exec_br ? {1'b0, w_taken} : r_pc_src;
    assign bus.gen         = r_gen;
    assign bus.alu_src_imm = r_alu_src_imm;
    assign bus.alu_op      = r_alu_op;
    assign bus.reg_write   = r_reg_write;
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.busy        = (r_state != c_S_FETCH) && (r_state != c_S_HALT);
    assign bus.err         = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_S_FETCH;
            r_op          <= '0;
            r_gen         <= 1'b0;
            r_alu_src_imm <= 1'b0;
            r_alu_op      <= c_ALU_PASS;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_pc_write    <= 1'b0;
            r_pc_src      <= c_PC_SEQ;
            r_wait        <= '0;
            r_err         <= 1'b0;
        end else begin
            // Write strobes are single-cycle unless re-armed below.
            r_reg_write <= 1'b0;
            r_pc_write  <= 1'b0;

            case (r_state)
                c_S_FETCH: begin
                    if (bus.instr_valid) begin
                        // Selects are set on entry to DECODE so the negedge
                        // immediate generator sees them a half-cycle early.
                        r_op          <= bus.opcode;
                        r_gen         <= (bus.opcode == c_OP_SVPC);
                        r_alu_src_imm <= f_use_imm(bus.opcode);
                        r_alu_op      <= f_alu_op(bus.opcode);
                        r_pc_src      <= c_PC_SEQ;
                        r_pc_write    <= (bus.opcode == c_OP_NOP);
                        r_state       <= c_S_DECODE;
                    end
                end

                c_S_DECODE: begin
                    if (!f_legal(r_op) || w_op_nop) begin
                        r_err         <= !f_legal(r_op);
                        r_state       <= f_legal(r_op) ? c_S_FETCH : c_S_HALT;
                        r_gen         <= 1'b0;
                        r_alu_src_imm <= 1'b0;
                        r_alu_op      <= c_ALU_PASS;
                        r_pc_src      <= c_PC_SEQ;
                    end else begin
                        r_state <= c_S_EXEC;
                        if (w_op_j) begin
                            r_pc_write <= 1'b1;
                            r_pc_src   <= c_PC_REG;
                        end else if (w_op_br) begin
                            r_pc_write <= 1'b1;
                        end
                    end
                end

                c_S_EXEC: begin
                    if (w_op_alu) begin
                        r_state     <= c_S_WB;
                        r_reg_write <= 1'b1;
                        r_pc_write  <= 1'b1;
                        r_pc_src    <= c_PC_SEQ;
                    end else if (w_op_ld || w_op_st || w_op_jm) begin
                        r_state     <= c_S_MEM;
                        r_wait      <= '0;
                        r_mem_read  <= w_op_ld || w_op_jm;
                        r_mem_write <= w_op_st;
                        r_pc_src    <= w_op_jm ? c_PC_MEM : c_PC_SEQ;
                    end else begin
                        r_state       <= c_S_FETCH;
                        r_gen         <= 1'b0;
                        r_alu_src_imm <= 1'b0;
                        r_alu_op      <= c_ALU_PASS;
                        r_pc_src      <= c_PC_SEQ;
                    end
                end

                c_S_MEM: begin
                    if (bus.mem_ready) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_wait      <= '0;
                        if (w_op_ld) begin
                            r_state     <= c_S_WB;
                            r_reg_write <= 1'b1;
                            r_pc_write  <= 1'b1;
                            r_pc_src    <= c_PC_SEQ;
                        end else begin
                            r_state       <= c_S_FETCH;
                            r_gen         <= 1'b0;
                            r_alu_src_imm <= 1'b0;
                            r_alu_op      <= c_ALU_PASS;
                            r_pc_src      <= c_PC_SEQ;
                        end
                    end else begin
                        r_wait <= w_wait_nxt;
                        if (w_wait_nxt == c_MEM_TMO) begin
                            r_err         <= 1'b1;
                            r_state       <= c_S_HALT;
                            r_mem_read    <= 1'b0;
                            r_mem_write   <= 1'b0;
                            r_gen         <= 1'b0;
                            r_alu_src_imm <= 1'b0;
                            r_alu_op      <= c_ALU_PASS;
                            r_pc_src      <= c_PC_SEQ;
                        end
                    end
                end

                c_S_WB: begin
                    r_state       <= c_S_FETCH;
                    r_gen         <= 1'b0;
                    r_alu_src_imm <= 1'b0;
                    r_alu_op      <= c_ALU_PASS;
                    r_pc_src      <= c_PC_SEQ;
                end

                c_S_HALT: begin
                    r_state <= c_S_HALT;
                end

                default: begin
                    // Unreachable encoding: treat as a fault.
                    r_err   <= 1'b1;
                    r_state <= c_S_HALT;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
